// File: rtl/pipelined_multiplier_param.sv
// Parametrised WIDTH x WIDTH pipelined shift-add multiplier with per-transaction signed mode,
// valid/ready handshake and global stall. Optional accumulate feature enabled by `define MULT_ACC_EN.
module pipelined_multiplier_param #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
`ifdef MULT_ACC_EN
  input  logic               in_acc,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product
);

  localparam int R  = WIDTH / STAGES;
  localparam int PW = 2 * WIDTH;

  // Adds partial-product rows first_row .. first_row+R-1 into the running sum. In signed mode
  // the top row of b carries negative weight, which keeps -2^(WIDTH-1) squared exact.
  function automatic logic [PW-1:0] fold_rows(
    input logic [PW-1:0]    sum_in,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sgn,
    input int               first_row
  );
    logic signed [PW-1:0] a_ext;
    logic [WIDTH-1:0]     b_sh;
    logic [PW-1:0]        acc;
    int                   row;
    a_ext = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    acc   = sum_in;
    for (int r = 0; r < R; r++) begin
      row  = first_row + r;
      b_sh = b >> row;
      if (b_sh[0]) begin
        if (sgn && (row == WIDTH - 1)) acc = acc - (a_ext << row);
        else                           acc = acc + (a_ext << row);
      end
    end
    return acc;
  endfunction

  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic             sgn_q [STAGES];
  logic             sgn_d [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [PW-1:0]    sum_q [STAGES];
  logic [PW-1:0]    sum_d [STAGES];
`ifdef MULT_ACC_EN
  logic             accf_q [STAGES];
  logic             accf_d [STAGES];
  logic [PW-1:0]    accum_q;
  logic [PW-1:0]    accum_d;
`endif

  logic advance;

  assign out_valid = vld_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      // Stage 1 boundary: capture operands and fold the lowest R rows
      assign vld_d[0] = in_valid;
      assign sgn_d[0] = in_signed;
      assign a_d[0]   = in_a;
      assign b_d[0]   = in_b;
      assign sum_d[0] = fold_rows({PW{1'b0}}, in_a, in_b, in_signed, 0);
`ifdef MULT_ACC_EN
      assign accf_d[0] = in_acc;
`endif
    end else begin : g_next
      // Stage s+1 boundary: fold the next R rows into the sum carried from stage s
      assign vld_d[s] = vld_q[s-1];
      assign sgn_d[s] = sgn_q[s-1];
      assign a_d[s]   = a_q[s-1];
      assign b_d[s]   = b_q[s-1];
      assign sum_d[s] = fold_rows(sum_q[s-1], a_q[s-1], b_q[s-1], sgn_q[s-1], s * R);
`ifdef MULT_ACC_EN
      assign accf_d[s] = accf_q[s-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s] <= 1'b0;
        sgn_q[s] <= 1'b0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
`ifdef MULT_ACC_EN
        accf_q[s] <= 1'b0;
`endif
      end
    end else if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s] <= vld_d[s];
        sgn_q[s] <= sgn_d[s];
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        sum_q[s] <= sum_d[s];
`ifdef MULT_ACC_EN
        accf_q[s] <= accf_d[s];
`endif
      end
    end
  end

`ifdef MULT_ACC_EN
  // Output boundary: optional accumulate; accumulator follows each delivered result
  assign out_product = accf_q[STAGES-1] ? (accum_q + sum_q[STAGES-1]) : sum_q[STAGES-1];
  assign accum_d     = (out_valid && out_ready) ? out_product : accum_q;

  always_ff @(posedge clk) begin
    if (rst) accum_q <= '0;
    else     accum_q <= accum_d;
  end
`else
  // Output boundary: bare product from the last stage
  assign out_product = sum_q[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_multiplier_param.sv
// Self-checking bench for pipelined_multiplier_param (WIDTH=4, STAGES=4) with a queue-based
// reference model; accumulate scenarios are compiled in when MULT_ACC_EN is defined.
module tb_pipelined_multiplier_param;
  localparam int WIDTH  = 4;
  localparam int STAGES = 4;
  localparam int PW     = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_signed = 1'b0;
  logic             tb_acc = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [PW-1:0]    out_product;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [PW-1:0] m_prod[$];
  logic          m_accf[$];
  logic [PW-1:0] model_acc = '0;

  // values sampled by tick()
  logic          s_in_ready, s_out_valid, s_out_hs, s_exp_ok;
  logic [PW-1:0] s_prod, s_exp;

  pipelined_multiplier_param #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
`ifdef MULT_ACC_EN
    .in_acc      (tb_acc),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic sgn);
    longint pa, pb;
    logic [63:0] t;
    if (sgn) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    t = 64'(pa * pb);
    return t[PW-1:0];
  endfunction

  // One clock: sample at the falling edge, update the model with both handshakes, advance.
  task automatic tick();
    logic [PW-1:0] p;
    logic f;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_prod      = out_product;
    s_out_hs    = out_valid && out_ready;
    s_exp_ok    = 1'b0;
    s_exp       = '0;
    if (s_out_hs && m_prod.size() > 0) begin
      p = m_prod.pop_front();
      f = m_accf.pop_front();
      s_exp     = f ? PW'(model_acc + p) : p;
      model_acc = s_exp;
      s_exp_ok  = 1'b1;
    end
    if (in_valid && in_ready) begin
      m_prod.push_back(ref_mul(in_a, in_b, in_signed));
      m_accf.push_back(tb_acc);
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one operation into an empty pipe and wait for its result.
  task automatic issue_single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic sgn, input logic acc,
                              output logic [PW-1:0] prod, output logic [PW-1:0] expv,
                              output int lat, output logic nextv, output logic timeout);
    logic got;
    got = 1'b0; lat = 0; prod = '0; expv = '0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = sgn; tb_acc = acc;
    tick();
    in_valid = 1'b0; tb_acc = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      tick();
      if (s_out_hs) begin
        got = 1'b1; lat = n; prod = s_prod; expv = s_exp;
      end
    end
    tick();
    nextv   = s_out_valid;
    timeout = !got;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++;
    if (out_product !== '0) begin n_fail++; $display("FAIL reset_out_product got=%h want=00", out_product); end
    rst = 1'b0;
    m_prod.delete(); m_accf.delete(); model_acc = '0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_op();
    logic [PW-1:0] prod, expv; int lat; logic nextv, to;
    issue_single(4'd3, 4'd5, 1'b0, 1'b0, prod, expv, lat, nextv, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL single_timeout no out_valid within budget"); end
    n_checks++;
    if (lat != STAGES) begin n_fail++; $display("FAIL single_latency got=%0d want=%0d", lat, STAGES); end
    n_checks++;
    if (prod !== 8'h0F) begin n_fail++; $display("FAIL single_product got=%h want=0f", prod); end
    n_checks++;
    if (nextv !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop got=%b want=0", nextv); end
  endtask

  task automatic test_signed_corners();
    logic [WIDTH-1:0] ta [5] = '{4'hD, 4'h8, 4'h8, 4'hF, 4'hF};
    logic [WIDTH-1:0] tbv[5] = '{4'h5, 4'h8, 4'h8, 4'hF, 4'hF};
    logic             ts [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [PW-1:0]    te [5] = '{8'hF1, 8'h40, 8'h40, 8'hE1, 8'h01};
    logic [PW-1:0] prod, expv; int lat; logic nextv, to;
    for (int i = 0; i < 5; i++) begin
      issue_single(ta[i], tbv[i], ts[i], 1'b0, prod, expv, lat, nextv, to);
      n_checks++;
      if (to || prod !== te[i]) begin
        n_fail++;
        $display("FAIL corner_%0d a=%h b=%h s=%b got=%h want=%h", i, ta[i], tbv[i], ts[i], prod, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nout, first;
    logic [PW-1:0] want;
    cyc = 0; nout = 0; first = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && nout < 16; i++) begin
      in_valid  = (i < 16);
      in_a      = WIDTH'(i);
      in_b      = WIDTH'(15 - i);
      in_signed = 1'b0;
      tick();
      if (i < 16) begin
        n_checks++;
        if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cycle=%0d got=%b want=1", i, s_in_ready); end
      end
      if (s_out_hs) begin
        if (first < 0) first = cyc;
        want = PW'(nout * (15 - nout));
        n_checks++;
        if (s_prod !== want || cyc != first + nout) begin
          n_fail++;
          $display("FAIL b2b_result idx=%0d got=%h want=%h cycle=%0d want_cycle=%0d", nout, s_prod, want, cyc, first + nout);
        end
        nout++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (nout != 16) begin n_fail++; $display("FAIL b2b_count got=%0d want=16", nout); end
  endtask

  task automatic test_backpressure();
    int sent, got, stall_left;
    logic stall_done;
    logic [PW-1:0] held;
    sent = 0; got = 0; stall_left = 0; stall_done = 1'b0; held = '0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      in_valid  = (sent < 6);
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      in_signed = 1'($urandom);
      if (!stall_done && out_valid) begin
        stall_left = 3; stall_done = 1'b1; held = out_product;
      end
      out_ready = (stall_left == 0);
      tick();
      if (in_valid && s_in_ready) sent++;
      if (stall_left > 0) begin
        n_checks++;
        if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_prod !== held) begin
          n_fail++;
          $display("FAIL bp_stall in_ready=%b out_valid=%b product=%h want in_ready=0 out_valid=1 product=%h",
                   s_in_ready, s_out_valid, s_prod, held);
        end
        stall_left--;
      end
      if (s_out_hs) begin
        got++;
        n_checks++;
        if (!s_exp_ok || s_prod !== s_exp) begin
          n_fail++; $display("FAIL bp_result idx=%0d got=%h want=%h", got, s_prod, s_exp);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got != 6) begin n_fail++; $display("FAIL bp_count got=%0d want=6", got); end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra_output got out_valid=%b want=0", s_out_valid); end
    end
  endtask

  task automatic test_midflight_reset();
    logic [PW-1:0] prod, expv; int lat; logic nextv, to;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'd5; in_b = 4'd7; in_signed = 1'b0;
    tick();
    in_a = 4'd9; in_b = 4'd3;
    tick();
    in_a = 4'd2; in_b = 4'd2; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    m_prod.delete(); m_accf.delete(); model_acc = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flush cycle=%0d out_valid=%b want=0", c, s_out_valid); end
    end
    issue_single(4'd6, 4'd7, 1'b0, 1'b0, prod, expv, lat, nextv, to);
    n_checks++;
    if (to || lat != STAGES || prod !== 8'h2A) begin
      n_fail++; $display("FAIL rst_after_op got=%h lat=%0d want=2a lat=%0d", prod, lat, STAGES);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 120; c++) begin
      in_valid  = 1'($urandom);
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      in_signed = 1'($urandom);
`ifdef MULT_ACC_EN
      tb_acc    = 1'($urandom);
`endif
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (s_out_hs) begin
        n_checks++;
        if (!s_exp_ok || s_prod !== s_exp) begin
          n_fail++; $display("FAIL rand_result cycle=%0d got=%h want=%h", c, s_prod, s_exp);
        end
      end
    end
    in_valid = 1'b0; tb_acc = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && m_prod.size() > 0; c++) begin
      tick();
      if (s_out_hs) begin
        n_checks++;
        if (!s_exp_ok || s_prod !== s_exp) begin
          n_fail++; $display("FAIL rand_drain got=%h want=%h", s_prod, s_exp);
        end
      end
    end
    n_checks++;
    if (m_prod.size() != 0) begin n_fail++; $display("FAIL rand_lost outstanding=%0d want=0", m_prod.size()); end
  endtask

`ifdef MULT_ACC_EN
  task automatic test_accumulate();
    logic [WIDTH-1:0] ta[3] = '{4'd2, 4'd4, 4'd1};
    logic [WIDTH-1:0] tbv[3] = '{4'd3, 4'd5, 4'd1};
    logic             tf[3] = '{1'b0, 1'b1, 1'b1};
    logic [PW-1:0]    te[3] = '{8'h06, 8'h1A, 8'h1B};
    logic [PW-1:0] prod, expv; int lat; logic nextv, to;
    for (int i = 0; i < 3; i++) begin
      issue_single(ta[i], tbv[i], 1'b0, tf[i], prod, expv, lat, nextv, to);
      n_checks++;
      if (to || prod !== te[i]) begin
        n_fail++; $display("FAIL acc_%0d got=%h want=%h", i, prod, te[i]);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_op();
    test_signed_corners();
    test_back_to_back();
    test_backpressure();
    test_midflight_reset();
`ifdef MULT_ACC_EN
    test_accumulate();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_multiplier_param.md
Name: pipelined_multiplier_param

Overview:
Parametrised N×N pipelined multiplier. It is the successor to the fixed 4-bit, always-flowing multiplier.
- Adds a per-transaction signed/unsigned mode.
- Adds a valid/ready handshake with backpressure.
- Pipeline depth is configurable.
- Sits between the input-switch capture logic and the output display/driver path of the tile. One result per cycle at full throughput.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH. Legal values are 2 to 16.
- STAGES, 4, number of pipeline stages (latency). WIDTH must be divisible by STAGES; each stage folds in WIDTH/STAGES partial-product rows.

Ports:
- clk  input  1  clock, all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and mode are valid this cycle
- in_ready  output  1  block can accept operands this cycle
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured per transaction
- out_valid  output  1  result is valid
- out_ready  input  1  downstream accepts the result
- out_product  output  2*WIDTH  product, or accumulation when the optional feature is enabled

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst, sampled at the rising edge of clk. Reset has priority over every other event.
- Reset values:
  - All stage-valid bits = 0, so out_valid = 0.
  - out_product = 0.
  - All data registers = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Stall rule: advance = !out_valid | out_ready (global stall).
  - in_ready = advance, driven combinationally.
  - When advance = 0, every stage register and stage-valid bit holds.
- Accept: an input is accepted when in_valid & in_ready. It enters stage 1 with its in_signed flag.
  - If in_valid = 0 while the pipeline advances, a bubble (valid = 0) enters.
- Latency: with no stall, an operand accepted at edge k has its result visible with out_valid = 1 after edge k+STAGES-1. That is STAGES register stages. Each stall cycle adds exactly one cycle.
- Throughput: 1 result per cycle when out_ready is held at 1.
- Arithmetic:
  - Stage i adds partial-product rows (i-1)*R to i*R-1, where R = WIDTH/STAGES, into a 2*WIDTH running sum.
  - in_a and in_b travel down the pipe alongside the sum.
  - Signed mode: operands are sign-extended to 2*WIDTH. The MSB row of in_b carries negative weight. The result is an exact two's-complement product truncated to 2*WIDTH bits. This is exact for all inputs, including -2^(WIDTH-1) squared.
  - Unsigned mode: exact unsigned product; no overflow is possible.
- Ordering: results leave strictly in acceptance order; no reordering or dropping.
- out_product and out_valid hold stable while out_valid & !out_ready.
- Reset mid-operation: all in-flight transactions are discarded and no result is emitted for them. out_valid = 0 on the next cycle.
- Simultaneous output and input handshakes in one cycle are legal. The pipeline shifts normally.

Optional Feature:
MULT_ACC_EN
- Defined:
  - Adds input port in_acc (1 bit), carried per transaction.
  - Adds a 2*WIDTH accumulator register, reset to 0.
  - When the final-stage transaction has in_acc = 1: out_product = accumulator + product, wrapping modulo 2^(2*WIDTH).
  - When in_acc = 0: out_product = product.
  - The accumulator is loaded with out_product on every output handshake (out_valid & out_ready).
  - Accumulator sign handling follows that transaction's in_signed flag; the addition is plain modulo.
- Undefined: in_acc and the accumulator do not exist; out_product is always the bare product.

Test Plan (WIDTH=4, STAGES=4):
- Reset then a single op: rst pulse, then a=3, b=5, unsigned, out_ready=1 → out_valid rises exactly 4 edges after accept; out_product = 8'h0F; out_valid = 0 the following cycle.
- Signed corners:
  - a=4'hD (-3), b=5, signed → 8'hF1
  - a=4'h8, b=4'h8, signed → 8'h40
  - same operands unsigned → 8'h40
  - a=4'hF, b=4'hF, unsigned → 8'hE1; signed → 8'h01
- Throughput: 16 back-to-back accepts, a=i, b=15-i, out_ready=1 → 16 consecutive out_valid cycles, in order, each product correct; in_ready constantly 1.
- Backpressure: stream of 6 ops with out_ready=0 for 3 cycles while out_valid=1 → in_ready=0 during the stall; out_product stable; no loss or duplication; order preserved after release.
- Mid-flight reset: accept 3 ops, assert rst at the 2nd edge after the first accept → no out_valid for any of them; the next op after reset yields a correct result with full latency.
- MULT_ACC_EN: ops (2,3,acc=0), (4,5,acc=1), (1,1,acc=1), unsigned → outputs 8'h06, 8'h1A, 8'h1B.
